// File: rtl/store_narrow_buffer_pkg.sv
// rtl/store_narrow_buffer_pkg.sv - store op encodings and queued store entry record
package store_narrow_buffer_pkg;

   localparam int SNB_AW = 32;

   typedef enum logic [1:0] {
      ST_NONE = 2'b00,
      ST_SB   = 2'b01,
      ST_SH   = 2'b10,
      ST_SW   = 2'b11
   } st_op_e;

   typedef struct packed {
      logic [SNB_AW-3:0] word;
      logic [31:0]       data;
      logic [3:0]        be;
   } entry_t;

endpackage

// File: rtl/store_narrow_buffer_if.sv
// rtl/store_narrow_buffer_if.sv - pipeline store/load and data-memory write port bundle
interface store_narrow_buffer_if #(parameter int AW = 32);
   logic [1:0]    st_op;
   logic [AW-1:0] st_addr;
   logic [31:0]   st_data;
   logic          st_stall;
   logic          st_misalign;
   logic [AW-1:0] ld_addr;
   logic          ld_en;
   logic          ld_hit;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [3:0]    mem_be;
   logic          mem_ack;
   logic          empty;

   modport master (
      output st_op, st_addr, st_data, ld_addr, ld_en, mem_ack,
      input  st_stall, st_misalign, ld_hit, mem_req, mem_addr, mem_wdata, mem_be, empty
   );

   modport slave (
      input  st_op, st_addr, st_data, ld_addr, ld_en, mem_ack,
      output st_stall, st_misalign, ld_hit, mem_req, mem_addr, mem_wdata, mem_be, empty
   );
endinterface

// File: rtl/store_narrow_buffer_lane_align.sv
// rtl/store_narrow_buffer_lane_align.sv - replicate store data onto byte lanes, build byte enables, flag misalignment
module store_lane_align
   import store_narrow_buffer_pkg::*;
(
   input  logic [1:0]  st_op,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] st_data,
   output logic [31:0] data,
   output logic [3:0]  be,
   output logic        misalign
);

   always_comb begin
      data     = st_data;
      be       = 4'b0000;
      misalign = 1'b0;
      case (st_op)
         ST_SB: begin
            data = {4{st_data[7:0]}};
            be   = 4'b0001 << addr_lo;
         end
         ST_SH: begin
            data     = {2{st_data[15:0]}};
            be       = addr_lo[1] ? 4'b1100 : 4'b0011;
            misalign = addr_lo[0];
         end
         ST_SW: begin
            be       = 4'b1111;
            misalign = (addr_lo != 2'b00);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/store_narrow_buffer.sv
// rtl/store_narrow_buffer.sv - store queue: narrows M-stage stores, buffers them and drains to data memory
module store_narrow_buffer
   import store_narrow_buffer_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = SNB_AW
)(
   input logic                  clk,
   input logic                  reset,
   store_narrow_buffer_if.slave bus
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   logic [PW-1:0]    rd_ptr, wr_ptr, rd_ptr_n;
   logic [PW:0]      count, count_left;
   logic [DEPTH-1:0] valid;
   entry_t           fifo [DEPTH];
   entry_t           new_entry;
   logic [31:0]      lane_data;
   logic [3:0]       lane_be;
   logic             lane_mis, is_store, full, push, pop, empty_w, misalign_q, hit;

   store_lane_align u_align (
      .st_op    (bus.st_op),
      .addr_lo  (bus.st_addr[1:0]),
      .st_data  (bus.st_data),
      .data     (lane_data),
      .be       (lane_be),
      .misalign (lane_mis)
   );

   assign is_store   = (bus.st_op != ST_NONE);
   assign empty_w    = (count == '0);
   assign full       = (count == FULL);
   // no bypass: a full queue refuses the push even when the head pops this cycle
   assign push       = is_store & ~lane_mis & ~full;
   assign pop        = ~empty_w & bus.mem_ack;
   assign count_left = count - (PW+1)'(pop);
   assign rd_ptr_n   = rd_ptr + PW'(pop);
   assign new_entry  = '{word: bus.st_addr[AW-1:2], data: lane_data, be: lane_be};

   assign bus.st_stall    = is_store & ~lane_mis & full;
   assign bus.st_misalign = misalign_q;
   assign bus.empty       = empty_w;
   assign bus.mem_req     = ~empty_w;

   always_ff @(posedge clk) begin
      if (push) fifo[wr_ptr] <= new_entry;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr        <= '0;
         wr_ptr        <= '0;
         count         <= '0;
         valid         <= '0;
         misalign_q    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.mem_be    <= '0;
      end else begin
         misalign_q <= is_store & lane_mis;
         count      <= count_left + (PW+1)'(push);
         rd_ptr     <= rd_ptr_n;
         if (pop) valid[rd_ptr] <= 1'b0;
         if (push) begin
            valid[wr_ptr] <= 1'b1;
            wr_ptr        <= wr_ptr + PW'(1);
         end
         // the head register is loaded from whatever entry becomes head after this edge
         if (push && count_left == '0) begin
            bus.mem_addr  <= {new_entry.word, 2'b00};
            bus.mem_wdata <= new_entry.data;
            bus.mem_be    <= new_entry.be;
         end else if (pop && count_left != '0) begin
            bus.mem_addr  <= {fifo[rd_ptr_n].word, 2'b00};
            bus.mem_wdata <= fifo[rd_ptr_n].data;
            bus.mem_be    <= fifo[rd_ptr_n].be;
         end
      end
   end

   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid[i] && fifo[i].word == bus.ld_addr[AW-1:2]) hit = 1'b1;
      end
   end

   assign bus.ld_hit = bus.ld_en & hit;

endmodule

// File: tb/tb_store_narrow_buffer.sv
// tb/tb_store_narrow_buffer.sv - directed self-checking bench with write scoreboard
module tb_store_narrow_buffer;
   import store_narrow_buffer_pkg::*;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   store_narrow_buffer_if #(.AW(32)) bus ();

   store_narrow_buffer #(.DEPTH(4), .AW(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // compare any write the DUT completes this cycle, then advance one clock
   task automatic cyc();
      exp_t e;
      if (bus.mem_req === 1'b1 && bus.mem_ack === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_write", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("mem_addr", bus.mem_addr, e.addr);
            chk("mem_wdata", bus.mem_wdata, e.data);
            chk("mem_be", bus.mem_be, e.be);
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic store(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data,
                        input logic exp_stall, input logic [31:0] exp_data, input logic [3:0] exp_be,
                        input logic enq);
      exp_t e;
      bus.st_op   = op;
      bus.st_addr = addr;
      bus.st_data = data;
      #1;
      chk("st_stall", bus.st_stall, exp_stall);
      if (enq && !exp_stall) begin
         e.addr = {addr[31:2], 2'b00};
         e.data = exp_data;
         e.be   = exp_be;
         sb.push_back(e);
      end
      cyc();
   endtask

   task automatic idle();
      bus.st_op = ST_NONE;
   endtask

   initial begin
      reset       = 1'b1;
      bus.st_op   = ST_NONE;
      bus.st_addr = '0;
      bus.st_data = '0;
      bus.ld_addr = '0;
      bus.ld_en   = 1'b0;
      bus.mem_ack = 1'b0;
      #1;
      chk("rst_mem_req", bus.mem_req, 0);
      chk("rst_empty", bus.empty, 1);
      chk("rst_stall", bus.st_stall, 0);
      chk("rst_ld_hit", bus.ld_hit, 0);
      chk("rst_misalign", bus.st_misalign, 0);
      chk("rst_mem_fields", {bus.mem_addr, bus.mem_wdata[27:0], bus.mem_be}, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // sb to top lane, ack high
      bus.mem_ack = 1'b1;
      store(ST_SB, 32'h1003, 32'hAABBCCDD, 0, 32'hDDDDDDDD, 4'b1000, 1);
      idle();
      #1;
      chk("sb_req", bus.mem_req, 1);
      chk("sb_addr_early", bus.mem_addr, 32'h1000);
      cyc();
      chk("sb_empty_after", bus.empty, 1);

      // sh upper half, then misaligned sh
      store(ST_SH, 32'h2002, 32'h12345678, 0, 32'h56785678, 4'b1100, 1);
      idle();
      cyc();
      store(ST_SH, 32'h2001, 32'h12345678, 0, 32'h0, 4'b0, 0);
      idle();
      #1;
      chk("misalign_pulse", bus.st_misalign, 1);
      chk("misalign_empty", bus.empty, 1);
      cyc();
      chk("misalign_gone", bus.st_misalign, 0);
      chk("misalign_no_req", bus.mem_req, 0);

      // fill with ack low, fifth stalls
      bus.mem_ack = 1'b0;
      for (int i = 0; i < 4; i++)
         store(ST_SW, 32'h100 + 32'(i * 4), 32'hA0000000 + 32'(i), 0, 32'hA0000000 + 32'(i), 4'hF, 1);
      store(ST_SW, 32'h200, 32'hB0000005, 1, 32'hB0000005, 4'hF, 1);
      bus.mem_ack = 1'b1;
      cyc();
      bus.mem_ack = 1'b0;
      store(ST_SW, 32'h200, 32'hB0000005, 0, 32'hB0000005, 4'hF, 1);
      idle();
      bus.mem_ack = 1'b1;
      for (int k = 0; k < 20 && sb.size() > 0; k++) cyc();
      chk("fill_drained", sb.size(), 0);
      chk("fill_empty", bus.empty, 1);

      // load hit against queued word
      bus.mem_ack = 1'b0;
      store(ST_SW, 32'h3000, 32'hCAFEF00D, 0, 32'hCAFEF00D, 4'hF, 1);
      idle();
      bus.ld_addr = 32'h3002;
      #1;
      chk("ld_hit_disabled", bus.ld_hit, 0);
      bus.ld_en = 1'b1;
      #1;
      chk("ld_hit_match", bus.ld_hit, 1);
      bus.ld_addr = 32'h3004;
      #1;
      chk("ld_hit_other_word", bus.ld_hit, 0);
      bus.ld_addr = 32'h3002;
      bus.mem_ack = 1'b1;
      cyc();
      chk("ld_hit_after_pop", bus.ld_hit, 0);
      bus.ld_en = 1'b0;

      // back-to-back with ack held high
      for (int i = 0; i < 10; i++) begin
         if (i > 0) chk("stream_req", bus.mem_req, 1);
         store(ST_SW, 32'h4000 + 32'(i * 4), 32'h5000 + 32'(i), 0, 32'h5000 + 32'(i), 4'hF, 1);
      end
      idle();
      cyc();
      chk("stream_drained", sb.size(), 0);
      chk("stream_empty", bus.empty, 1);

      // async reset mid-drain
      bus.mem_ack = 1'b0;
      for (int i = 0; i < 3; i++)
         store(ST_SW, 32'h6000 + 32'(i * 4), 32'(i), 0, 32'(i), 4'hF, 1);
      idle();
      #2;
      chk("pre_rst_req", bus.mem_req, 1);
      reset = 1'b1;
      #1;
      chk("async_rst_req", bus.mem_req, 0);
      chk("async_rst_empty", bus.empty, 1);
      sb.delete();
      @(negedge clk);
      reset = 1'b0;
      bus.mem_ack = 1'b1;
      store(ST_SB, 32'h5001, 32'h00000011, 0, 32'h11111111, 4'b0010, 1);
      idle();
      cyc();
      chk("post_rst_drained", sb.size(), 0);
      chk("post_rst_empty", bus.empty, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
